pipe_hazard_sb: RTL and testbench

Parametrised hazard/stall unit for the in-order MIPS pipeline, sitting beside the D stage. It replaces per-stage Tnew/RegWrite/RegDst/jal decoding with an internal scoreboard: each issued instruction's destination and Tnew are recorded and aged stage by stage. From the scoreboard it produces the D-stage stall, per-source forwarding selects, and a multiply/divide busy interlock, for any pipeline depth behind D.

---
 rtl/pipe_hazard_sb_pkg.sv | 32 +++
 rtl/pipe_hazard_mdu_cnt.sv | 37 +++
 rtl/pipe_hazard_sb.sv | 119 +++++++++++
 tb/tb_pipe_hazard_sb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_sb_pkg.sv
// Shared types and constants for the pipe_hazard_sb scoreboard hazard unit:
// entry layout, Tnew/Tuse encodings, MDU latencies and fwd_sel width helpers.
package pipe_hazard_sb_pkg;

  localparam int DEF_AW       = 5;
  localparam int DEF_TW       = 3;
  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  localparam logic [DEF_TW-1:0] TNEW_ALU    = 3'd1;
  localparam logic [DEF_TW-1:0] TNEW_LOAD   = 3'd2;
  localparam logic [DEF_TW-1:0] TNEW_JAL    = 3'd0;
  localparam logic [DEF_TW-1:0] TUSE_BRANCH = 3'd0;
  localparam logic [DEF_TW-1:0] TUSE_ALU    = 3'd1;

  // Scoreboard entry layout for the default address/Tnew widths.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [DEF_AW-1:0] dst;
    logic [DEF_TW-1:0] tnew;
  } sb_entry_t;

  function automatic int fwd_sel_w(input int nstage);
    return $clog2(nstage + 32'sd1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_hazard_mdu_cnt.sv
// Multiply/divide busy counter for pipe_hazard_sb; only present when
// PIPE_HAZARD_MDU_EN is defined.
`ifdef PIPE_HAZARD_MDU_EN
module pipe_hazard_mdu_cnt
  import pipe_hazard_sb_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic div,
  output logic busy
);

  localparam int CW = $clog2(max_int(MULT_LAT, DIV_LAT) + 32'sd1);

  logic [CW-1:0] cnt_r;

  // Load the op latency on issue, otherwise count down to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CW'(32'sd1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != '0);

endmodule
`endif

// File: rtl/pipe_hazard_sb.sv
// Scoreboard-based D-stage hazard unit: stall, forwarding selects and an
// optional MDU busy interlock (enabled by defining PIPE_HAZARD_MDU_EN).
module pipe_hazard_sb
  import pipe_hazard_sb_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int NSRC     = 2,
  parameter int AW       = DEF_AW,
  parameter int TW       = DEF_TW,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 d_valid,
  input  logic [NSRC*AW-1:0]                   d_src,
  input  logic [NSRC*TW-1:0]                   d_Tuse,
  input  logic                                 d_we,
  input  logic [AW-1:0]                        d_dst,
  input  logic [TW-1:0]                        d_Tnew,
  input  logic                                 d_mdu_start,
  input  logic                                 d_mdu_div,
  input  logic                                 d_mdu_use,
  output logic                                 stall,
  output logic [NSRC*fwd_sel_w(NSTAGE)-1:0]    fwd_sel,
  output logic [NSRC-1:0]                      fwd_rdy,
  output logic                                 mdu_busy
);

  localparam int FW = fwd_sel_w(NSTAGE);

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t                       sb_r [NSTAGE];
  entry_t                       d_entry_s;
  logic [NSRC-1:0]              data_stall_s;
  logic [NSRC-1:0][FW-1:0]      idx_s;
  logic [NSRC-1:0][TW-1:0]      tn_s;
  logic                         mdu_stall_s;

  function automatic entry_t age(input entry_t e);
    entry_t r;
    r = e;
    r.tnew = (e.tnew != '0) ? (e.tnew - TW'(32'sd1)) : e.tnew;
    return r;
  endfunction

  // D-stage instruction as it would be recorded in entry 0.
  always_comb begin
    d_entry_s       = '0;
    d_entry_s.valid = d_valid;
    d_entry_s.we    = d_we;
    d_entry_s.dst   = d_dst;
    d_entry_s.tnew  = d_Tnew;
  end

  // Shift the scoreboard; a stall inserts a bubble behind D.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTAGE; i++) begin
        sb_r[i] <= '0;
      end
    end else begin
      sb_r[0] <= stall ? '0 : d_entry_s;
      for (int i = 1; i < NSTAGE; i++) begin
        sb_r[i] <= age(sb_r[i-1]);
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer is kept.
  always_comb begin
    idx_s        = '0;
    tn_s         = '0;
    data_stall_s = '0;
    fwd_sel      = '0;
    fwd_rdy      = '1;
    for (int s = 0; s < NSRC; s++) begin
      for (int i = NSTAGE - 1; i >= 0; i--) begin
        idx_s[s] = (sb_r[i].valid && sb_r[i].we &&
                    (sb_r[i].dst == d_src[s*AW +: AW]) &&
                    (d_src[s*AW +: AW] != '0)) ? FW'(i + 32'sd1) : idx_s[s];
        tn_s[s]  = (idx_s[s] == FW'(i + 32'sd1)) ? sb_r[i].tnew : tn_s[s];
      end
      fwd_sel[s*FW +: FW] = idx_s[s];
      fwd_rdy[s]          = (idx_s[s] == '0) ? 1'b1 : (tn_s[s] == '0);
      data_stall_s[s]     = (idx_s[s] != '0) && (tn_s[s] > d_Tuse[s*TW +: TW]);
    end
  end

`ifdef PIPE_HAZARD_MDU_EN
  pipe_hazard_mdu_cnt #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdu_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (!stall && d_valid && d_mdu_start),
    .div     (d_mdu_div),
    .busy    (mdu_busy)
  );

  assign mdu_stall_s = d_mdu_use & mdu_busy;
`else
  logic mdu_unused_s;

  assign mdu_unused_s = ^{d_mdu_start, d_mdu_div, d_mdu_use};
  assign mdu_stall_s  = 1'b0;
  assign mdu_busy     = 1'b0;
`endif

  assign stall = d_valid & ((|data_stall_s) | mdu_stall_s);

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Directed scoreboard bench for pipe_hazard_sb: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pipe_hazard_sb;
  import pipe_hazard_sb_pkg::*;

`ifdef PIPE_HAZARD_MDU_EN
  localparam logic MDU_EN = 1'b1;
`else
  localparam logic MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       d_valid = 1'b0;
  logic [9:0] d_src = '0;
  logic [5:0] d_Tuse = '0;
  logic       d_we = 1'b0;
  logic [4:0] d_dst = '0;
  logic [2:0] d_Tnew = '0;
  logic       d_mdu_start = 1'b0;
  logic       d_mdu_div = 1'b0;
  logic       d_mdu_use = 1'b0;
  logic       stall;
  logic [3:0] fwd_sel;
  logic [1:0] fwd_rdy;
  logic       mdu_busy;

  pipe_hazard_sb #(
    .NSTAGE(3), .NSRC(2), .AW(5), .TW(3), .MULT_LAT(5), .DIV_LAT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_src(d_src),
    .d_Tuse(d_Tuse), .d_we(d_we), .d_dst(d_dst), .d_Tnew(d_Tnew),
    .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div), .d_mdu_use(d_mdu_use),
    .stall(stall), .fwd_sel(fwd_sel), .fwd_rdy(fwd_rdy), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic [3:0] sel;
    logic [1:0] rdy;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  mon_e;
  string mon_n;

  // One D-stage cycle: drive inputs, queue the expected response, advance.
  task automatic step(input logic rst, input logic v,
                      input logic [4:0] s0, input logic [2:0] u0,
                      input logic [4:0] s1, input logic [2:0] u1,
                      input logic we, input logic [4:0] dst, input logic [2:0] tn,
                      input logic ms, input logic md, input logic mu,
                      input logic es, input logic [3:0] esel,
                      input logic [1:0] erdy, input logic eb, input string nm);
    reset_n     = ~rst;
    d_valid     = v;
    d_src       = {s1, s0};
    d_Tuse      = {u1, u0};
    d_we        = we;
    d_dst       = dst;
    d_Tnew      = tn;
    d_mdu_start = ms;
    d_mdu_div   = md;
    d_mdu_use   = mu;
    exp_q.push_back('{stall: es, sel: esel, rdy: erdy, busy: eb});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (stall !== mon_e.stall) begin
        errors++;
        $display("FAIL %s stall: got %0b expected %0b", mon_n, stall, mon_e.stall);
      end
      checks++;
      if (fwd_sel !== mon_e.sel) begin
        errors++;
        $display("FAIL %s fwd_sel: got %b expected %b", mon_n, fwd_sel, mon_e.sel);
      end
      checks++;
      if (fwd_rdy !== mon_e.rdy) begin
        errors++;
        $display("FAIL %s fwd_rdy: got %b expected %b", mon_n, fwd_rdy, mon_e.rdy);
      end
      checks++;
      if (mdu_busy !== mon_e.busy) begin
        errors++;
        $display("FAIL %s mdu_busy: got %0b expected %0b", mon_n, mdu_busy, mon_e.busy);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    //   rst v  s0 u0 s1 u1 we dst tn  ms md mu  stall sel rdy busy
    step(1'b1, 1'b0, 5'd0, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, 1'b0, "reset");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd9, 3'd2, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, 1'b0, "lw9_issue");
    step(1'b0, 1'b1, 5'd9, 3'd1, 5'd0, 3'd1, 1'b1, 5'd10, 3'd1, 1'b0, 1'b0, 1'b0,
         1'b1, 4'b0001, 2'b10, 1'b0, "load_use_stall");
    step(1'b0, 1'b1, 5'd9, 3'd1, 5'd0, 3'd1, 1'b1, 5'd10, 3'd1, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0010, 2'b10, 1'b0, "load_use_fwd");
    step(1'b0, 1'b1, 5'd10, 3'd0, 5'd9, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b1, 4'b1101, 2'b10, 1'b0, "branch_stall");
    step(1'b0, 1'b1, 5'd10, 3'd0, 5'd9, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0010, 2'b11, 1'b0, "branch_fwd");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, 1'b0, "add9");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd9, 3'd1, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, 1'b0, "addi9");
    step(1'b0, 1'b1, 5'd9, 3'd1, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0001, 2'b10, 1'b0, "youngest_wins");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd0, 3'd2, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, 1'b0, "lw_to_zero");
    step(1'b0, 1'b1, 5'd0, 3'd0, 5'd9, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b1100, 2'b11, 1'b0, "zero_read");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd31, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, 1'b0, "jal");
    step(1'b0, 1'b1, 5'd31, 3'd0, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0001, 2'b11, 1'b0, "jal_read");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd12, 3'd2, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, 1'b0, "lw12");
    step(1'b0, 1'b0, 5'd12, 3'd0, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0001, 2'b10, 1'b0, "invalid_no_stall");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b1,
         1'b0, 4'b0000, 2'b11, 1'b0, "div_issue");
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd8, 3'd1, 1'b0, 1'b0, 1'b1,
           MDU_EN, 4'b0000, 2'b11, MDU_EN, $sformatf("mfhi_stall%0d", k));
    end
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd8, 3'd1, 1'b0, 1'b0, 1'b1,
         1'b0, 4'b0000, 2'b11, 1'b0, "mfhi_go");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1,
         1'b0, 4'b0000, 2'b11, 1'b0, "mult1");
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1,
           MDU_EN, 4'b0000, 2'b11, MDU_EN, $sformatf("mult2_stall%0d", k));
    end
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1,
         1'b0, 4'b0000, 2'b11, 1'b0, "mult2_go");
    step(1'b0, 1'b0, 5'd0, 3'd1, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, MDU_EN, "mult2_busy");
    step(1'b0, 1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 1'b1, 5'd7, 3'd2, 1'b0, 1'b0, 1'b0,
         1'b0, 4'b0000, 2'b11, MDU_EN, "lw7_pre_reset");
    step(1'b1, 1'b1, 5'd7, 3'd0, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1,
         1'b0, 4'b0000, 2'b11, 1'b0, "reset_async");
    step(1'b0, 1'b1, 5'd7, 3'd0, 5'd0, 3'd1, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1,
         1'b0, 4'b0000, 2'b11, 1'b0, "post_reset");
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
